alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, two-stage pipelined successor to the single-cycle 32-bit ALU of the ARM processor datapath. Accepts operand pairs and an opcode over a valid/ready handshake, computes one of eight integer operations, and returns the result with a passthrough tag so the UVM scoreboard can match out-of-order checks to requests. Supports full-throughput streaming, back-pressure, and optional status flags.

## Interface
- WIDTH, 32: operand/result width; ≥ 8, power of two.
- TAG_W, 4: request tag width; ≥ 1.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted when in_valid && in_ready at a rising clock edge.
- in_1  in  WIDTH  operand A.
- in_2  in  WIDTH  operand B.
- op  in  3  opcode.
- in_tag  in  TAG_W  request tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts when out_valid && out_ready at a rising clock edge.
- out_res  out  WIDTH  result.
- out_tag  out  TAG_W  tag of the request producing out_res.
- out_flags  out  4  {N,Z,C,V}; present only with ALU_FLAGS_EN.

## Operation
- Opcodes: 000 ADD, 001 SUB (A−B), 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SRA.
- Shift amount = in_2[$clog2(WIDTH)-1:0]; upper bits ignored. Shift by 0 returns A.
- ADD/SUB wrap modulo 2^WIDTH; no saturation.
- Stage S1: registers A, B, op, tag, s1_valid. Stage S2: computes the result from the S1 registers, then registers out_res, out_tag, out_flags, and out_valid.
- Advance rules: S2 loads when !out_valid || out_ready. S1 loads when !s1_valid || S2 loads. in_ready = !s1_valid || S2 loads (combinational from out_ready, no skid buffer).
- While out_valid && !out_ready: out_res, out_tag, out_flags and out_valid hold stable. S1 holds once full. in_ready drops.
- Order is preserved; capacity is 2 requests in flight.
- Reset: s1_valid = 0, out_valid = 0, out_res = 0, out_tag = 0, out_flags = 0. in_ready = 1 in the first cycle after reset.
- Reset while requests are in flight: all in-flight requests are discarded and no result is produced for them. A request offered in the reset cycle is not accepted.
- Same-edge accept on both sides with the pipe full: S2 unloads, S1 moves to S2, and the new request enters S1. No bubble is inserted.

## Timing
- Latency: a request accepted at edge n produces out_valid at edge n+2, provided out_ready was held high.
- Throughput: 1 result per cycle while out_ready = 1.
- in_ready has a combinational path from out_ready. out_res has no combinational path from inputs.
- A valid request must not be dropped: the driver holds in_valid, in_1, in_2, op and in_tag stable until accepted.

## Configuration
- ALU_FLAGS_EN defined:
  - out_flags exists.
  - N = res[WIDTH-1]; Z = (res == 0).
  - ADD: C = carry-out; V = signed overflow.
  - SUB: C = no-borrow (A ≥ B unsigned); V = signed overflow.
  - Logic and shift ops: C = 0 and V = 0, except SLL/SRL/SRA with nonzero shift, where C = the last bit shifted out.
  - Flags are registered and held with out_res.
- ALU_FLAGS_EN undefined: the out_flags port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset then a single ADD, A=0xFFFF_FFFF, B=1, tag=3, out_ready=1:
  - out_res=0 and out_tag=3 exactly 2 cycles after accept.
  - With flags enabled: Z=1, C=1, V=0.
- Back-to-back stream: 8 requests, one per cycle, covering ops 000–111 with A=0x8000_00F0, B=4, out_ready=1:
  - 8 consecutive results, in order, 1 per cycle.
  - SRA gives 0xF800_000F; SLL gives 0x0000_0F00.
- Back-pressure with out_ready=0 for 5 cycles during a stream:
  - in_ready falls after 2 accepts.
  - out_res and out_tag stay stable.
  - When out_ready=1 is released, both results emerge, then streaming resumes with no loss or duplication.
- SUB with A=0x7FFF_FFFF, B=0xFFFF_FFFF:
  - out_res=0x8000_0000.
  - With flags enabled: V=1, N=1, C=0.
- Reset asserted for 1 cycle with 2 requests in flight:
  - out_valid=0 on the next cycle; no stale result ever appears.
  - The next request after reset returns after exactly 2 cycles.
- Shift-amount masking: SLL with A=1, B=0x0000_0021 (WIDTH=32) -> out_res=0x2.

Source files
------------

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe
// Purpose  : Two-stage pipelined integer ALU with a valid/ready handshake on
//            both sides and a passthrough request tag.
//            S1 registers the request, and S2 computes and registers the result.
//            The pipeline holds at most two requests, streams one result per
//            cycle, and keeps results in request order.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            in_valid/in_ready   - request handshake
//            in_1, in_2, op      - operands A, B and opcode
//            in_tag              - request tag, returned with the result
//            out_valid/out_ready - result handshake
//            out_res, out_tag    - result and its tag
//            out_flags           - {N,Z,C,V}, only when ALU_FLAGS_EN is defined
// Config   : `define ALU_FLAGS_EN adds the out_flags port and its logic.
// Revision : 1.0 - initial release
// ============================================================================
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic [2:0]       op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [TAG_W-1:0] out_tag
`ifdef ALU_FLAGS_EN
  ,
  output logic [3:0]       out_flags
`endif
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [2:0] c_OP_ADD = 3'b000;
  localparam logic [2:0] c_OP_SUB = 3'b001;
  localparam logic [2:0] c_OP_AND = 3'b010;
  localparam logic [2:0] c_OP_OR  = 3'b011;
  localparam logic [2:0] c_OP_XOR = 3'b100;
  localparam logic [2:0] c_OP_SLL = 3'b101;
  localparam logic [2:0] c_OP_SRL = 3'b110;
  localparam logic [2:0] c_OP_SRA = 3'b111;

  // S1 registers
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  // S2 registers
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_res_q, out_res_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
`ifdef ALU_FLAGS_EN
  logic [3:0]       out_flags_q, out_flags_d;
`endif

  // Advance controls
  logic s2_load;
  logic s1_load;

  // ALU datapath
  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] alu_res;
`ifdef ALU_FLAGS_EN
  logic             alu_c;
  logic             alu_v;
`endif

  always_comb begin
    s2_load = !out_valid_q || out_ready;
    s1_load = !s1_valid_q || s2_load;
  end

  // Reset dominates the accept, so ready is withheld during reset to keep the
  // upstream driver from treating a reset-cycle request as consumed.
  assign in_ready = s1_load && !rst;

  assign shamt = b_q[SH_W-1:0];

  // Result computation from the S1 registers
  always_comb begin
    alu_res = '0;
`ifdef ALU_FLAGS_EN
    alu_c   = 1'b0;
    alu_v   = 1'b0;
`endif
    case (op_q)
      c_OP_ADD: begin
`ifdef ALU_FLAGS_EN
        {alu_c, alu_res} = {1'b0, a_q} + {1'b0, b_q};
        alu_v = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
`else
        alu_res = a_q + b_q;
`endif
      end
      c_OP_SUB: begin
`ifdef ALU_FLAGS_EN
        // A + ~B + 1: the carry-out is the no-borrow indication.
        {alu_c, alu_res} = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
        alu_v = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
`else
        alu_res = a_q - b_q;
`endif
      end
      c_OP_AND: alu_res = a_q & b_q;
      c_OP_OR:  alu_res = a_q | b_q;
      c_OP_XOR: alu_res = a_q ^ b_q;
      // The shifts use a one-bit extension to catch the last bit shifted out.
      // A zero shift leaves the extension bit at 0, so C stays clear.
      c_OP_SLL: begin
`ifdef ALU_FLAGS_EN
        {alu_c, alu_res} = {1'b0, a_q} << shamt;
`else
        alu_res = a_q << shamt;
`endif
      end
      c_OP_SRL: begin
`ifdef ALU_FLAGS_EN
        {alu_res, alu_c} = {a_q, 1'b0} >> shamt;
`else
        alu_res = a_q >> shamt;
`endif
      end
      c_OP_SRA: begin
`ifdef ALU_FLAGS_EN
        {alu_res, alu_c} = $signed({a_q, 1'b0}) >>> shamt;
`else
        alu_res = $signed(a_q) >>> shamt;
`endif
      end
      default: alu_res = '0;
    endcase
  end

  // Next-state logic for both stages
  always_comb begin
    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    tag_d      = tag_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        a_d   = in_1;
        b_d   = in_2;
        op_d  = op;
        tag_d = in_tag;
      end
    end

    out_valid_d = out_valid_q;
    out_res_d   = out_res_q;
    out_tag_d   = out_tag_q;
`ifdef ALU_FLAGS_EN
    out_flags_d = out_flags_q;
`endif
    // When S2 loads from an empty S1, the output data holds and only valid drops.
    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_res_d = alu_res;
        out_tag_d = tag_q;
`ifdef ALU_FLAGS_EN
        out_flags_d = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      tag_q       <= '0;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_tag_q   <= '0;
`ifdef ALU_FLAGS_EN
      out_flags_q <= '0;
`endif
    end else begin
      s1_valid_q  <= s1_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      tag_q       <= tag_d;
      out_valid_q <= out_valid_d;
      out_res_q   <= out_res_d;
      out_tag_q   <= out_tag_d;
`ifdef ALU_FLAGS_EN
      out_flags_q <= out_flags_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_res   = out_res_q;
  assign out_tag   = out_tag_q;
`ifdef ALU_FLAGS_EN
  assign out_flags = out_flags_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_pipe
// Purpose  : Self-checking bench for alu_pipe. It uses directed scenarios and
//            a randomized stream, and checks them against a queue-based
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

  localparam int WIDTH = 32;
  localparam int TAG_W = 4;
  localparam longint S_MAX = 64'sd2147483647;
  localparam longint S_MIN = -64'sd2147483648;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_1;
  logic [WIDTH-1:0] in_2;
  logic [2:0]       op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;
  logic [TAG_W-1:0] out_tag;
`ifdef ALU_FLAGS_EN
  logic [3:0]       out_flags;
`endif

  int cnt_cmp  = 0;
  int cnt_fail = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  tag;
    logic [3:0]  flags;
  } exp_t;

  alu_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_1      (in_1),
    .in_2      (in_2),
    .op        (op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_tag   (out_tag)
`ifdef ALU_FLAGS_EN
    ,
    .out_flags (out_flags)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog");
  end

  // Reference model. It works from the arithmetic definitions: a 64-bit sum
  // for the carry, the signed range for overflow, and an unsigned compare for
  // no-borrow.
  function automatic exp_t model(input logic [2:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic [3:0] t);
    exp_t e;
    longint unsigned ua, ub, wide;
    longint sa, sb, sw;
    int s;
    logic c, v;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = int'(b[4:0]);
    c  = 1'b0;
    v  = 1'b0;
    e.res = 32'd0;
    case (o)
      3'd0: begin
        wide = ua + ub; e.res = wide[31:0]; c = wide[32];
        sw = sa + sb; v = (sw > S_MAX) || (sw < S_MIN);
      end
      3'd1: begin
        e.res = a - b; c = (a >= b);
        sw = sa - sb; v = (sw > S_MAX) || (sw < S_MIN);
      end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd4: e.res = a ^ b;
      3'd5: begin e.res = a << s; if (s != 0) c = a[32-s]; end
      3'd6: begin e.res = a >> s; if (s != 0) c = a[s-1]; end
      default: begin e.res = $signed(a) >>> s; if (s != 0) c = a[s-1]; end
    endcase
    e.tag   = t;
    e.flags = {e.res[31], (e.res == 32'd0), c, v};
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_1 = '0; in_2 = '0; op = '0; in_tag = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    cnt_cmp++; if (out_valid !== 1'b0) begin cnt_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    cnt_cmp++; if (out_res !== 32'd0) begin cnt_fail++; $display("FAIL reset_out_res: got %h want 0", out_res); end
    cnt_cmp++; if (out_tag !== 4'd0) begin cnt_fail++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
    cnt_cmp++; if (in_ready !== 1'b1) begin cnt_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
`ifdef ALU_FLAGS_EN
    cnt_cmp++; if (out_flags !== 4'd0) begin cnt_fail++; $display("FAIL reset_out_flags: got %b want 0000", out_flags); end
`endif
  endtask

  // Accept at edge n, S2 loads at edge n+1, and the consumer takes at edge n+2.
  task automatic test_add_wrap();
    out_ready = 1'b1;
    in_valid = 1'b1; in_1 = 32'hFFFF_FFFF; in_2 = 32'd1; op = 3'b000; in_tag = 4'd3;
    #1;
    cnt_cmp++; if (in_ready !== 1'b1) begin cnt_fail++; $display("FAIL add_in_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    cnt_cmp++; if (out_valid !== 1'b0) begin cnt_fail++; $display("FAIL add_early_valid: got %b want 0", out_valid); end
    tick();
    cnt_cmp++; if (out_valid !== 1'b1) begin cnt_fail++; $display("FAIL add_latency_valid: got %b want 1", out_valid); end
    cnt_cmp++; if (out_res !== 32'd0) begin cnt_fail++; $display("FAIL add_res: got %h want 00000000", out_res); end
    cnt_cmp++; if (out_tag !== 4'd3) begin cnt_fail++; $display("FAIL add_tag: got %h want 3", out_tag); end
`ifdef ALU_FLAGS_EN
    cnt_cmp++; if (out_flags !== 4'b0110) begin cnt_fail++; $display("FAIL add_flags: got %b want 0110", out_flags); end
`endif
    tick();
    cnt_cmp++; if (out_valid !== 1'b0) begin cnt_fail++; $display("FAIL add_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got_res [8];
    logic [3:0]  got_tag [8];
    logic [3:0]  got_flg [8];
    int          got_cyc [8];
    int          ngot = 0;
    int          sent = 0;
    exp_t        e;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (sent < 8) begin
        in_valid = 1'b1; in_1 = 32'h8000_00F0; in_2 = 32'd4;
        op = sent[2:0]; in_tag = sent[3:0];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready && ngot < 8) begin
        got_res[ngot] = out_res; got_tag[ngot] = out_tag; got_cyc[ngot] = cyc;
`ifdef ALU_FLAGS_EN
        got_flg[ngot] = out_flags;
`else
        got_flg[ngot] = 4'd0;
`endif
        ngot++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0;
    cnt_cmp++; if (ngot !== 8) begin cnt_fail++; $display("FAIL b2b_count: got %0d want 8", ngot); end
    cnt_cmp++; if (ngot > 0 && got_cyc[0] !== 2) begin cnt_fail++; $display("FAIL b2b_first_latency: got cycle %0d want 2", got_cyc[0]); end
    for (int i = 0; i < ngot; i++) begin
      e = model(i[2:0], 32'h8000_00F0, 32'd4, i[3:0]);
      cnt_cmp++; if (got_res[i] !== e.res || got_tag[i] !== e.tag) begin
        cnt_fail++; $display("FAIL b2b_result[%0d]: got %h/tag %h want %h/tag %h", i, got_res[i], got_tag[i], e.res, e.tag);
      end
`ifdef ALU_FLAGS_EN
      cnt_cmp++; if (got_flg[i] !== e.flags) begin cnt_fail++; $display("FAIL b2b_flags[%0d]: got %b want %b", i, got_flg[i], e.flags); end
`endif
      if (i > 0) begin
        cnt_cmp++; if (got_cyc[i] !== got_cyc[i-1] + 1) begin cnt_fail++; $display("FAIL b2b_gap[%0d]: got cycle %0d want %0d", i, got_cyc[i], got_cyc[i-1] + 1); end
      end
    end
    if (ngot == 8) begin
      cnt_cmp++; if (got_res[7] !== 32'hF800_000F) begin cnt_fail++; $display("FAIL b2b_sra: got %h want f800000f", got_res[7]); end
      cnt_cmp++; if (got_res[5] !== 32'h0000_0F00) begin cnt_fail++; $display("FAIL b2b_sll: got %h want 00000f00", got_res[5]); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] av [6];
    logic [31:0] bv [6];
    logic [2:0]  ov [6];
    exp_t        q [$];
    exp_t        e;
    int          sent = 0, ngot = 0, acc_stall = 0;
    logic        held = 1'b0;
    logic [31:0] hres = '0;
    logic [3:0]  htag = '0;
    for (int i = 0; i < 6; i++) begin
      av[i] = $urandom; bv[i] = $urandom; ov[i] = 3'($urandom_range(0, 7));
    end
    for (int cyc = 0; cyc < 40 && ngot < 6; cyc++) begin
      out_ready = (cyc >= 5);
      in_valid  = (sent < 6);
      if (sent < 6) begin
        in_1 = av[sent]; in_2 = bv[sent]; op = ov[sent]; in_tag = 4'(8 + sent);
      end
      #1;
      if (cyc < 5) begin
        if (cyc >= 2) begin
          cnt_cmp++; if (in_ready !== 1'b0) begin cnt_fail++; $display("FAIL bp_in_ready[c%0d]: got %b want 0", cyc, in_ready); end
        end
        if (out_valid === 1'b1) begin
          if (!held) begin
            held = 1'b1; hres = out_res; htag = out_tag;
          end else begin
            cnt_cmp++; if (out_res !== hres || out_tag !== htag) begin
              cnt_fail++; $display("FAIL bp_hold[c%0d]: got %h/%h want %h/%h", cyc, out_res, out_tag, hres, htag);
            end
          end
        end
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          cnt_cmp++; cnt_fail++; $display("FAIL bp_unexpected: got %h/%h want none", out_res, out_tag);
        end else begin
          e = q.pop_front();
          cnt_cmp++; if (out_res !== e.res || out_tag !== e.tag) begin
            cnt_fail++; $display("FAIL bp_result[%0d]: got %h/%h want %h/%h", ngot, out_res, out_tag, e.res, e.tag);
          end
        end
        ngot++;
      end
      if (in_valid && in_ready) begin
        if (cyc < 5) acc_stall++;
        q.push_back(model(op, in_1, in_2, in_tag));
        sent++;
      end
      tick();
    end
    in_valid = 1'b0;
    cnt_cmp++; if (held !== 1'b1) begin cnt_fail++; $display("FAIL bp_stall_valid: got %b want 1", held); end
    cnt_cmp++; if (acc_stall !== 2) begin cnt_fail++; $display("FAIL bp_accepts_during_stall: got %0d want 2", acc_stall); end
    cnt_cmp++; if (ngot !== 6 || q.size() != 0) begin cnt_fail++; $display("FAIL bp_count: got %0d results want 6", ngot); end
    for (int k = 0; k < 3; k++) begin
      #1;
      cnt_cmp++; if (out_valid !== 1'b0) begin cnt_fail++; $display("FAIL bp_duplicate[%0d]: got %b want 0", k, out_valid); end
      tick();
    end
  endtask

  task automatic test_sub_overflow();
    int wait_cyc = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_1 = 32'h7FFF_FFFF; in_2 = 32'hFFFF_FFFF; op = 3'b001; in_tag = 4'd6;
    tick();
    in_valid = 1'b0;
    while (out_valid !== 1'b1 && wait_cyc < 10) begin tick(); wait_cyc++; end
    cnt_cmp++; if (out_valid !== 1'b1) begin cnt_fail++; $display("FAIL sub_timeout: got valid %b want 1", out_valid); end
    cnt_cmp++; if (out_res !== 32'h8000_0000 || out_tag !== 4'd6) begin cnt_fail++; $display("FAIL sub_res: got %h/%h want 80000000/6", out_res, out_tag); end
`ifdef ALU_FLAGS_EN
    cnt_cmp++; if (out_flags !== 4'b1001) begin cnt_fail++; $display("FAIL sub_flags: got %b want 1001", out_flags); end
`endif
    tick();
  endtask

  task automatic test_shift_mask();
    int wait_cyc = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_1 = 32'd1; in_2 = 32'h0000_0021; op = 3'b101; in_tag = 4'd9;
    tick();
    in_valid = 1'b0;
    while (out_valid !== 1'b1 && wait_cyc < 10) begin tick(); wait_cyc++; end
    cnt_cmp++; if (out_res !== 32'h0000_0002 || out_tag !== 4'd9) begin cnt_fail++; $display("FAIL shift_mask: got %h/%h want 00000002/9", out_res, out_tag); end
`ifdef ALU_FLAGS_EN
    cnt_cmp++; if (out_flags !== 4'b0000) begin cnt_fail++; $display("FAIL shift_mask_flags: got %b want 0000", out_flags); end
`endif
    tick();
  endtask

  task automatic test_reset_inflight();
    out_ready = 1'b0;
    in_valid = 1'b1; in_1 = 32'd7; in_2 = 32'd8; op = 3'b000; in_tag = 4'd1;
    tick();
    in_tag = 4'd2;
    tick();
    // Pipe now full: S2 holds tag 1, S1 holds tag 2. A third request is offered with reset.
    rst = 1'b1; in_tag = 4'd11;
    #1;
    cnt_cmp++; if (in_ready !== 1'b0) begin cnt_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      cnt_cmp++; if (out_valid !== 1'b0) begin cnt_fail++; $display("FAIL rst_stale[%0d]: got valid %b tag %h want 0", k, out_valid, out_tag); end
      tick();
    end
    in_valid = 1'b1; in_1 = 32'd10; in_2 = 32'd20; op = 3'b000; in_tag = 4'd5;
    #1;
    cnt_cmp++; if (in_ready !== 1'b1) begin cnt_fail++; $display("FAIL rst_post_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    cnt_cmp++; if (out_valid !== 1'b0) begin cnt_fail++; $display("FAIL rst_post_early: got %b want 0", out_valid); end
    tick();
    cnt_cmp++; if (out_valid !== 1'b1 || out_res !== 32'd30 || out_tag !== 4'd5) begin
      cnt_fail++; $display("FAIL rst_post_result: got v%b %h/%h want v1 0000001e/5", out_valid, out_res, out_tag);
    end
    tick();
  endtask

  task automatic test_random();
    exp_t q [$];
    exp_t e;
    int   sent = 0;
    logic pending = 1'b0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (!pending && sent < 150 && $urandom_range(0, 3) != 0) begin
        pending = 1'b1;
        case ($urandom_range(0, 4))
          0: in_1 = 32'h0000_0000;
          1: in_1 = 32'hFFFF_FFFF;
          2: in_1 = 32'h8000_0000;
          3: in_1 = 32'h7FFF_FFFF;
          default: in_1 = $urandom;
        endcase
        in_2   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        op     = 3'($urandom_range(0, 7));
        in_tag = 4'($urandom_range(0, 15));
      end
      in_valid  = pending;
      out_ready = (sent >= 150) || ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          cnt_cmp++; cnt_fail++; $display("FAIL rand_unexpected[c%0d]: got %h/%h want none", cyc, out_res, out_tag);
        end else begin
          e = q.pop_front();
          cnt_cmp++; if (out_res !== e.res || out_tag !== e.tag) begin
            cnt_fail++; $display("FAIL rand_result[c%0d]: got %h/%h want %h/%h", cyc, out_res, out_tag, e.res, e.tag);
          end
`ifdef ALU_FLAGS_EN
          cnt_cmp++; if (out_flags !== e.flags) begin cnt_fail++; $display("FAIL rand_flags[c%0d]: got %b want %b", cyc, out_flags, e.flags); end
`endif
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(op, in_1, in_2, in_tag));
        pending = 1'b0;
        sent++;
      end
      tick();
    end
    in_valid = 1'b0;
    cnt_cmp++; if (sent !== 150 || q.size() != 0) begin
      cnt_fail++; $display("FAIL rand_drain: got sent %0d pending %0d want 150/0", sent, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_back_to_back();
    test_backpressure();
    test_sub_overflow();
    test_shift_mask();
    test_reset_inflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt_cmp, cnt_fail);
    $finish;
  end

endmodule
`default_nettype wire
